spi_master_cfg: RTL and testbench

SPI_MASTER_CFG -- requirements
Module: spi_master_cfg

---
 rtl/spi_pkg.sv | 27 ++
 rtl/spi_clk_gen.sv | 46 ++++
 rtl/spi_master_cfg.sv | 186 ++++++++++++++++++
 tb/tb_spi_master_cfg.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// -----------------------------------------------------------------------------
// spi_pkg
// Types and constants shared by the SPI master and its testbench.
//   spi_state_e : transfer phases (IDLE, LEAD, XFER, TRAIL)
//   MODE0..3    : {CPOL,CPHA} encodings for the mode input
//   cs_width()  : width of the chip-select index (at least one bit)
// -----------------------------------------------------------------------------
package spi_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LEAD  = 2'd1,
        ST_XFER  = 2'd2,
        ST_TRAIL = 2'd3
    } spi_state_e;

    // {CPOL,CPHA}
    localparam logic [1:0] MODE0 = 2'b00;
    localparam logic [1:0] MODE1 = 2'b01;
    localparam logic [1:0] MODE2 = 2'b10;
    localparam logic [1:0] MODE3 = 2'b11;

    function automatic int cs_width(input int num_cs);
        return (num_cs > 1) ? $clog2(num_cs) : 1;
    endfunction

endpackage

// File: rtl/spi_clk_gen.sv
// -----------------------------------------------------------------------------
// spi_clk_gen
// Half-period timer for the SPI master. The divider is latched on load_i;
// while en_i is high the counter runs and tick_o pulses for one clk cycle at
// the end of every half-period of div_i+1 cycles.
// Ports:
//   clk    : system clock, rising edge
//   rst_ni : asynchronous active-low reset
//   load_i : latch div_i and restart the count
//   div_i  : half-period length minus one
//   en_i   : count enable (high while a transfer is in progress)
//   tick_o : one-cycle pulse on the last cycle of each half-period
// -----------------------------------------------------------------------------
module spi_clk_gen #(
    parameter int DIV_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_ni,
    input  logic                 load_i,
    input  logic [DIV_WIDTH-1:0] div_i,
    input  logic                 en_i,
    output logic                 tick_o
);

    logic [DIV_WIDTH-1:0] div_q;
    logic [DIV_WIDTH-1:0] cnt_q;

    assign tick_o = en_i && (cnt_q == div_q);

    // NOTE: sequential state uses non-blocking (<=) so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            div_q <= '0;
            cnt_q <= '0;
        end else if (load_i) begin
            div_q <= div_i;
            cnt_q <= '0;
        end else if (en_i) begin
            cnt_q <= tick_o ? '0 : cnt_q + 1'b1;
        end else begin
            cnt_q <= '0;
        end
    end

endmodule

// File: rtl/spi_master_cfg.sv
// -----------------------------------------------------------------------------
// spi_master_cfg
// Single-word SPI master with runtime mode, divider and chip-select choice.
// A start in IDLE captures data_in/cs_sel/mode/div, then the block walks
// LEAD (CS low, SCK idle) -> XFER (2*DATA_WIDTH SCK half-periods) -> TRAIL,
// and returns to IDLE with a one-cycle done pulse and data_out updated.
// Ports:
//   clk, rst          : clock (rising edge), asynchronous active-low reset
//   start             : transfer request, only looked at in IDLE
//   data_in           : word to transmit
//   cs_sel            : slave index; values >= NUM_CS assert no chip select
//   mode              : {CPOL,CPHA}
//   div               : SCK half-period = div+1 clk cycles
//   miso / mosi, sck  : serial lines
//   cs_n              : active-low chip selects
//   data_out          : last received word
//   busy, done        : transfer in progress / one-cycle completion pulse
// Build option: SPI_MASTER_LSB_FIRST_EN adds input lsb_first (captured at
// start) selecting LSB-first order in both directions; otherwise MSB first.
// -----------------------------------------------------------------------------
module spi_master_cfg
    import spi_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int NUM_CS     = 4,
    parameter int DIV_WIDTH  = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic [DATA_WIDTH-1:0]         data_in,
    input  logic [cs_width(NUM_CS)-1:0]   cs_sel,
    input  logic [1:0]                    mode,
    input  logic [DIV_WIDTH-1:0]          div,
    input  logic                          miso,
`ifdef SPI_MASTER_LSB_FIRST_EN
    input  logic                          lsb_first,
`endif
    output logic                          mosi,
    output logic                          sck,
    output logic [NUM_CS-1:0]             cs_n,
    output logic [DATA_WIDTH-1:0]         data_out,
    output logic                          busy,
    output logic                          done
);

    localparam int HALF_W = $clog2(2 * DATA_WIDTH);
    localparam logic [HALF_W-1:0] LAST_HALF = HALF_W'(2 * DATA_WIDTH - 1);

    spi_state_e            state_q;
    logic [DATA_WIDTH-1:0] tx_q;
    logic [DATA_WIDTH-1:0] rx_q;
    logic [DATA_WIDTH-1:0] data_out_q;
    logic [HALF_W-1:0]     half_q;
    logic [NUM_CS-1:0]     cs_n_q;
    logic                  cpha_q;
    logic                  lsb_q;
    logic                  sck_q;
    logic                  mosi_q;
    logic                  done_q;

    logic [NUM_CS-1:0]     cs_n_d;
    logic [DATA_WIDTH-1:0] rx_d;
    logic                  lsb_in;
    logic                  accept;
    logic                  tick;
    logic                  sample_edge;
    logic                  last_half;

`ifdef SPI_MASTER_LSB_FIRST_EN
    assign lsb_in = lsb_first;
`else
    assign lsb_in = 1'b0;
`endif

    // Bit that goes on the wire next, and the word with that bit consumed.
    function automatic logic lead_bit(input logic [DATA_WIDTH-1:0] w, input logic lsb);
        return lsb ? w[0] : w[DATA_WIDTH-1];
    endfunction

    function automatic logic [DATA_WIDTH-1:0] shift_word(input logic [DATA_WIDTH-1:0] w,
                                                         input logic lsb);
        return lsb ? (w >> 1) : (w << 1);
    endfunction

    assign busy   = (state_q != ST_IDLE);
    assign accept = (state_q == ST_IDLE) && start;

    // Even half-periods end in a leading edge. CPHA=0 samples on leading
    // edges, CPHA=1 on trailing edges; the other edge shifts mosi.
    assign sample_edge = ~half_q[0] ^ cpha_q;
    assign last_half   = (half_q == LAST_HALF);

    assign rx_d = lsb_q ? {miso, rx_q[DATA_WIDTH-1:1]} : {rx_q[DATA_WIDTH-2:0], miso};

    // NOTE: give every always_comb output a default before any condition so
    // no path leaves it unassigned (which would infer a latch).
    always_comb begin
        cs_n_d = '1;
        for (int i = 0; i < NUM_CS; i++) begin
            if (int'(cs_sel) == i) cs_n_d[i] = 1'b0;
        end
    end

    spi_clk_gen #(
        .DIV_WIDTH (DIV_WIDTH)
    ) u_clk_gen (
        .clk    (clk),
        .rst_ni (rst),
        .load_i (accept),
        .div_i  (div),
        .en_i   (busy),
        .tick_o (tick)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            tx_q       <= '0;
            rx_q       <= '0;
            data_out_q <= '0;
            half_q     <= '0;
            cs_n_q     <= '1;
            cpha_q     <= 1'b0;
            lsb_q      <= 1'b0;
            sck_q      <= 1'b0;
            mosi_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        cpha_q  <= mode[0];
                        lsb_q   <= lsb_in;
                        sck_q   <= mode[1];
                        cs_n_q  <= cs_n_d;
                        half_q  <= '0;
                        state_q <= ST_LEAD;
                        // CPHA=0 needs the first bit valid before the first edge.
                        if (!mode[0]) begin
                            mosi_q <= lead_bit(data_in, lsb_in);
                            tx_q   <= shift_word(data_in, lsb_in);
                        end else begin
                            tx_q   <= data_in;
                        end
                    end
                end
                ST_LEAD: begin
                    if (tick) state_q <= ST_XFER;
                end
                ST_XFER: begin
                    if (tick) begin
                        sck_q  <= ~sck_q;
                        half_q <= half_q + 1'b1;
                        if (sample_edge) begin
                            rx_q <= rx_d;
                        end else if (!(last_half && !cpha_q)) begin
                            // The final CPHA=0 trailing edge has no bit left to
                            // present, so mosi keeps the last bit.
                            mosi_q <= lead_bit(tx_q, lsb_q);
                            tx_q   <= shift_word(tx_q, lsb_q);
                        end
                        if (last_half) state_q <= ST_TRAIL;
                    end
                end
                ST_TRAIL: begin
                    if (tick) begin
                        cs_n_q     <= '1;
                        data_out_q <= rx_q;
                        done_q     <= 1'b1;
                        state_q    <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign sck      = sck_q;
    assign mosi     = mosi_q;
    assign cs_n     = cs_n_q;
    assign data_out = data_out_q;
    assign done     = done_q;

endmodule

// File: tb/tb_spi_master_cfg.sv
// -----------------------------------------------------------------------------
// tb_spi_master_cfg
// Self-checking bench for spi_master_cfg (DATA_WIDTH=8, NUM_CS=4). A second
// instance with NUM_CS=3 runs in lock-step with cs_sel tied to 3 so that an
// out-of-range slave index can be exercised. The reference is a protocol-level
// SPI slave: it presents a word on miso, collects mosi on its sampling edges,
// and the expected latency, chip-select pattern and data come from plain
// arithmetic on the transfer parameters.
// -----------------------------------------------------------------------------
module tb_spi_master_cfg;
    import spi_pkg::*;

    localparam int DW  = 8;
    localparam int NCS = 4;
    localparam int DVW = 8;

    logic           clk       = 1'b0;
    logic           rst       = 1'b1;
    logic           start     = 1'b0;
    logic           miso      = 1'b0;
    logic [DW-1:0]  data_in   = '0;
    logic [1:0]     cs_sel    = '0;
    logic [1:0]     mode      = '0;
    logic [DVW-1:0] div       = '0;
    logic           lsb_first = 1'b0;
    logic [1:0]     cs_sel_oor = 2'd3;

    logic           mosi, sck, busy, done;
    logic [NCS-1:0] cs_n;
    logic [DW-1:0]  data_out;

    logic           mosi_oor, sck_oor, busy_oor, done_oor;
    logic [2:0]     cs_n_oor;
    logic [DW-1:0]  data_out_oor;

    int total = 0;
    int bad   = 0;

    logic last_bit  = 1'b0;
    logic last_cpol = 1'b0;

    always #5 clk = ~clk;

    spi_master_cfg #(.DATA_WIDTH(DW), .NUM_CS(NCS), .DIV_WIDTH(DVW)) dut (
        .clk(clk), .rst(rst), .start(start), .data_in(data_in), .cs_sel(cs_sel),
        .mode(mode), .div(div), .miso(miso),
`ifdef SPI_MASTER_LSB_FIRST_EN
        .lsb_first(lsb_first),
`endif
        .mosi(mosi), .sck(sck), .cs_n(cs_n), .data_out(data_out),
        .busy(busy), .done(done)
    );

    spi_master_cfg #(.DATA_WIDTH(DW), .NUM_CS(3), .DIV_WIDTH(DVW)) dut_oor (
        .clk(clk), .rst(rst), .start(start), .data_in(data_in), .cs_sel(cs_sel_oor),
        .mode(mode), .div(div), .miso(miso),
`ifdef SPI_MASTER_LSB_FIRST_EN
        .lsb_first(lsb_first),
`endif
        .mosi(mosi_oor), .sck(sck_oor), .cs_n(cs_n_oor), .data_out(data_out_oor),
        .busy(busy_oor), .done(done_oor)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    // Position of the k-th bit on the wire.
    function automatic int bidx(input int k, input bit lsb);
        return lsb ? k : DW - 1 - k;
    endfunction

    task automatic idle_check(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check("idle_busy", busy, 0);
            check("idle_done", done, 0);
            check("idle_cs_n", cs_n, 4'hF);
            check("idle_sck", sck, last_cpol);
            check("idle_mosi_hold", mosi, last_bit);
        end
    endtask

    // One transfer. Inputs are applied at the current time (a falling edge),
    // the next rising edge is the accept edge. Returns on the falling edge
    // where done is seen. hold keeps start high for a back-to-back request;
    // abort_at >= 0 pulls reset once the slave has collected that many bits.
    task automatic run_xfer(input logic [DW-1:0] tx, input logic [1:0] sel,
                            input logic [1:0] md, input logic [DVW-1:0] dv,
                            input logic [DW-1:0] sw, input bit lsb,
                            input bit hold, input int abort_at);
        int             n_exp, edges, n_rx, n_tx, n_sck;
        bit             finished, aborted, leading, prev_sck, cpol, cpha;
        bit             saw_done, saw_sck;
        logic [DW-1:0]  slave_rx;
        logic [NCS-1:0] exp_cs;

        n_exp    = (2 * DW + 2) * (int'(dv) + 1) + 1;
        cpol     = md[1];
        cpha     = md[0];
        prev_sck = cpol;
        exp_cs   = '1;
        exp_cs[sel] = 1'b0;
        n_rx = 0; n_tx = 0; n_sck = 0;
        finished = 0; aborted = 0;
        slave_rx = '0;

        start = 1'b1; data_in = tx; cs_sel = sel; mode = md; div = dv; lsb_first = lsb;
        @(posedge clk);
        edges = 1;

        for (int c = 0; c < n_exp + 8 && !finished; c++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                finished = 1;
                if (!hold) start = 1'b0;
                check("latency", edges, n_exp);
                check("busy_at_done", busy, 0);
                check("cs_n_at_done", cs_n, 4'hF);
                check("sck_at_done", sck, cpol);
                check("data_out", data_out, sw);
                check("slave_rx_mosi", slave_rx, tx);
                check("sck_edges", n_sck, 2 * DW);
                check("oor_done", done_oor, 1);
                check("oor_data_out", data_out_oor, sw);
                last_bit  = tx[bidx(DW - 1, lsb)];
                last_cpol = cpol;
            end else begin
                if (c == 0) begin
                    check("busy_on_accept", busy, 1);
                    check("sck_lead_idle", sck, cpol);
                    if (!hold) start = 1'b0;
                    if (!cpha) begin
                        check("mosi_first_bit", mosi, tx[bidx(0, lsb)]);
                        miso = sw[bidx(0, lsb)];
                        n_tx = 1;
                    end
                end else begin
                    // Everything below must be ignored while busy.
                    data_in = DW'($urandom); cs_sel = 2'($urandom); mode = 2'($urandom);
                    div = DVW'($urandom); lsb_first = 1'($urandom);
                    if (!hold) start = 1'($urandom);
                end
                check("busy", busy, 1);
                check("cs_n", cs_n, exp_cs);
                check("oor_cs_n", cs_n_oor, 3'b111);

                if (sck !== prev_sck) begin
                    n_sck++;
                    leading  = (prev_sck == cpol);
                    prev_sck = sck;
                    if (leading != cpha) begin
                        if (n_rx < DW) slave_rx[bidx(n_rx, lsb)] = mosi;
                        n_rx++;
                    end else begin
                        if (n_tx < DW) miso = sw[bidx(n_tx, lsb)];
                        n_tx++;
                    end
                end

                if (abort_at >= 0 && n_rx == abort_at) begin
                    rst = 1'b0;
                    start = 1'b0;
                    #1;
                    check("rst_cs_n", cs_n, 4'hF);
                    check("rst_oor_cs_n", cs_n_oor, 3'b111);
                    check("rst_sck", sck, 0);
                    check("rst_busy", busy, 0);
                    check("rst_done", done, 0);
                    check("rst_mosi", mosi, 0);
                    check("rst_data_out", data_out, 0);
                    finished = 1;
                    aborted  = 1;
                end else begin
                    @(posedge clk);
                    edges++;
                end
            end
        end

        if (!finished) begin
            check("done_seen", finished, 1);
            start = 1'b0;
        end

        if (aborted) begin
            repeat (2) @(negedge clk);
            rst = 1'b1;
            saw_done = 0;
            saw_sck  = 0;
            for (int c = 0; c < n_exp + 4; c++) begin
                @(negedge clk);
                if (done !== 1'b0) saw_done = 1;
                if (sck !== 1'b0) saw_sck = 1;
            end
            check("no_done_after_reset", saw_done, 0);
            check("sck_low_after_reset", saw_sck, 0);
            check("busy_after_reset", busy, 0);
            last_bit  = 1'b0;
            last_cpol = 1'b0;
        end
    endtask

    initial begin
        bit lsb;
        #2 rst = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_sck", sck, 0);
        check("reset_mosi", mosi, 0);
        check("reset_cs_n", cs_n, 4'hF);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_data_out", data_out, 0);
        rst = 1'b1;
        idle_check(3);

        // Mode 0, fastest clock, A5 out / 3C back.
        run_xfer(8'hA5, 2'd0, MODE0, 8'd0, 8'h3C, 1'b0, 1'b0, -1);
        idle_check(2);

        // Mode 3 with div=3: SCK idles high.
        run_xfer(8'hA5, 2'd0, MODE3, 8'd3, 8'h3C, 1'b0, 1'b0, -1);
        idle_check(2);

        // start held through two transfers on slaves 1 then 2.
        run_xfer(8'h96, 2'd1, MODE0, 8'd1, 8'h69, 1'b0, 1'b1, -1);
        run_xfer(8'h3C, 2'd2, MODE2, 8'd0, 8'hE1, 1'b0, 1'b0, -1);
        idle_check(2);

        // Reset while bit 4 is in flight.
        run_xfer(8'hC3, 2'd0, MODE0, 8'd1, 8'h5A, 1'b0, 1'b0, 4);
        idle_check(2);

        // Largest divider.
        run_xfer(8'h5A, 2'd3, MODE1, 8'hFF, 8'hC3, 1'b0, 1'b0, -1);
        idle_check(2);

`ifdef SPI_MASTER_LSB_FIRST_EN
        run_xfer(8'h01, 2'd0, MODE0, 8'd0, 8'hB4, 1'b1, 1'b0, -1);
        idle_check(2);
`endif

        for (int t = 0; t < 24; t++) begin
            lsb = 1'b0;
`ifdef SPI_MASTER_LSB_FIRST_EN
            lsb = 1'($urandom_range(0, 1));
`endif
            run_xfer(DW'($urandom), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                     DVW'($urandom_range(0, 4)), DW'($urandom), lsb, 1'b0, -1);
            idle_check($urandom_range(1, 3));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
